// File: rtl/seq_game_ctrl_pkg.sv
// Shared types for the memory-game round controller: FSM states, colour type
// and a helper used to size the tick counter.
package seq_game_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_WAIT_IN,
      S_WIN,
      S_LOSE
   } state_t;

   typedef logic [1:0] colour_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/seq_game_ctrl_store.sv
// Colour sequence register file: one synchronous write port, one
// asynchronous read port.
module seq_game_ctrl_store
   import seq_game_ctrl_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  colour_t       wdata_i,
   input  logic [AW-1:0] raddr_i,
   output colour_t       rdata_o
);

   colour_t mem_q [DEPTH];

   // NOTE: contents carry no reset; each entry is written in ADD before any read of it.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/seq_game_ctrl.sv
// Memory-game round controller: grows the colour sequence, plays it on the
// LEDs, then checks the player's presses against it.
module seq_game_ctrl
   import seq_game_ctrl_pkg::*;
#(
   parameter  int SEQ_MAX       = 16,
   parameter  int SHOW_TICKS    = 4,
   parameter  int GAP_TICKS     = 2,
   parameter  int TIMEOUT_TICKS = 20,
   localparam int W             = $clog2(SEQ_MAX + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick_en,
   input  logic         start,
   input  logic [1:0]   rand_bits,
   input  logic         btn_valid,
   input  logic [1:0]   btn_code,
   output logic         led_on,
   output logic [1:0]   led_code,
   output logic         input_ready,
   output logic [W-1:0] round,
   output logic         win,
   output logic         lose
);

   localparam int AW = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
   localparam int TW = $clog2(max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);

   state_t          state_q, state_d;
   logic [W-1:0]    len_q, len_d;
   logic [W-1:0]    idx_q, idx_d, idx_inc;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            we, last_idx, show_end, gap_end, to_end, next_show;
   logic [AW-1:0]   show_idx;
   colour_t         rdata, show_code;
   logic            led_on_q, input_ready_q, win_q, lose_q;
   colour_t         led_code_q;
   logic [W-1:0]    round_q;

   assign idx_inc  = idx_q + W'(1);
   assign last_idx = (idx_q == len_q - W'(1));
   assign show_end = (tcnt_q == TW'(SHOW_TICKS - 1));
   assign gap_end  = (tcnt_q == TW'(GAP_TICKS - 1));
   assign to_end   = (tcnt_q == TW'(TIMEOUT_TICKS - 1));
   assign we       = (state_q == S_ADD);

   // The read address follows the index the show phase is about to use, so
   // the registered led_code lines up with led_on on the same edge.
   assign next_show = (state_q == S_SHOW_OFF) && tick_en && gap_end && !last_idx;
   assign show_idx  = (state_q == S_ADD) ? '0 :
                      next_show          ? idx_inc[AW-1:0] : idx_q[AW-1:0];
   assign show_code = (we && len_q[AW-1:0] == show_idx) ? rand_bits : rdata;

   seq_game_ctrl_store #(
      .DEPTH (SEQ_MAX),
      .AW    (AW)
   ) u_store (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (len_q[AW-1:0]),
      .wdata_i (rand_bits),
      .raddr_i (show_idx),
      .rdata_o (rdata)
   );

   always_comb begin
      // NOTE: every _d defaults to its _q first so no branch can infer a latch.
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) begin
               len_d   = '0;
               idx_d   = '0;
               tcnt_d  = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            len_d   = len_q + W'(1);
            idx_d   = '0;
            tcnt_d  = '0;
            state_d = S_SHOW_ON;
         end
         S_SHOW_ON: begin
            if (tick_en) begin
               if (show_end) begin
                  tcnt_d  = '0;
                  state_d = S_SHOW_OFF;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         S_SHOW_OFF: begin
            if (tick_en) begin
               if (gap_end) begin
                  tcnt_d = '0;
                  if (last_idx) begin
                     idx_d   = '0;
                     state_d = S_WAIT_IN;
                  end else begin
                     idx_d   = idx_inc;
                     state_d = S_SHOW_ON;
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         S_WAIT_IN: begin
            if (btn_valid) begin
               tcnt_d = '0;
               if (btn_code != rdata)    state_d = S_LOSE;
               else if (!last_idx)       idx_d   = idx_inc;
               else if (len_q == W'(SEQ_MAX)) state_d = S_WIN;
               else                      state_d = S_ADD;
            end else if (tick_en) begin
               if (to_end) begin
                  tcnt_d  = '0;
                  state_d = S_LOSE;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         idx_q         <= '0;
         tcnt_q        <= '0;
         led_on_q      <= 1'b0;
         led_code_q    <= '0;
         input_ready_q <= 1'b0;
         round_q       <= '0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         tcnt_q        <= tcnt_d;
         led_on_q      <= (state_d == S_SHOW_ON);
         led_code_q    <= (state_d == S_SHOW_ON) ? show_code : '0;
         input_ready_q <= (state_d == S_WAIT_IN);
         round_q       <= len_d;
         win_q         <= (state_d == S_WIN);
         lose_q        <= (state_d == S_LOSE);
      end
   end

   assign led_on      = led_on_q;
   assign led_code    = led_code_q;
   assign input_ready = input_ready_q;
   assign round       = round_q;
   assign win         = win_q;
   assign lose        = lose_q;

endmodule
